// File: rtl/frame_wr_pkg.sv
// Shared types and sizes for the frame write arbiter and its byte bank.
package frame_wr_pkg;

  localparam int unsigned BYTES  = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = BYTES * BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/frame_wr_arbiter_byte_bank.sv
// Eight byte lanes assembled into one word; a lane changes only when written.
module byte_bank
  import frame_wr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [BYTE_W-1:0] din,
  output logic [WORD_W-1:0] q
);

  logic [BYTE_W-1:0] lane_q [BYTES];
  logic [BYTE_W-1:0] lane_d [BYTES];

  always_comb begin
    for (int unsigned i = 0; i < BYTES; i++) begin
      lane_d[i] = lane_q[i];
      if (we && (addr == IDX_W'(i))) begin
        lane_d[i] = din;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (rst) begin
        lane_q[i] <= '0;
      end else begin
        lane_q[i] <= lane_d[i];
      end
    end
  end

  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    assign q[g*BYTE_W +: BYTE_W] = lane_q[g];
  end

endmodule

// File: rtl/frame_wr_arbiter.sv
// Round-robin arbiter granting one 8-byte write bank per frame to one of two
// byte streams, with stall timeout abort and a valid/ready word output.
module frame_wr_arbiter
  import frame_wr_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 8
) (
  input  logic              w_clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [BYTE_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [BYTE_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              frame_valid,
  output logic [WORD_W-1:0] frame_data,
  output logic              frame_src,
  input  logic              frame_ready,
  output logic              abort,
  output logic              abort_src
);

  localparam logic [CW-1:0]    STALL_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]    STALL_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BYTES - 1);

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CW-1:0]     stall_q, stall_d;
  logic              rdy0_q, rdy0_d;
  logic              rdy1_q, rdy1_d;
  logic              fv_q, fv_d;
  logic              fsrc_q, fsrc_d;
  logic              abort_q, abort_d;
  logic              asrc_q, asrc_d;

  logic              gnt_valid_c;
  logic [BYTE_W-1:0] gnt_data_c;
  logic              accept_c;
  logic              bank_we_c;

  assign gnt_valid_c = gnt_q ? req1_valid : req0_valid;
  assign gnt_data_c  = gnt_q ? req1_data  : req0_data;
  assign accept_c    = gnt_valid_c && (gnt_q ? rdy1_q : rdy0_q);

  // Next state, arbitration, byte indexing and stall tracking.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    idx_d     = idx_q;
    stall_d   = stall_q;
    fv_d      = fv_q;
    fsrc_d    = fsrc_q;
    abort_d   = 1'b0;
    asrc_d    = asrc_q;
    bank_we_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt_d   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          last_d  = gnt_d;
          idx_d   = '0;
          stall_d = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept_c) begin
          bank_we_c = 1'b1;
          stall_d   = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_HOLD;
            fv_d    = 1'b1;
            fsrc_d  = gnt_q;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (stall_q == STALL_LAST) begin
          // Source went quiet too long: drop the partial frame.
          abort_d = 1'b1;
          asrc_d  = gnt_q;
          stall_d = '0;
          idx_d   = '0;
          state_d = ST_IDLE;
        end else if (stall_q != STALL_MAX) begin
          stall_d = stall_q + CW'(1);
        end
      end
      ST_HOLD: begin
        if (frame_ready) begin
          fv_d    = 1'b0;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rdy0_d = (state_d == ST_FILL) && !gnt_d;
    rdy1_d = (state_d == ST_FILL) && gnt_d;
  end

  always_ff @(posedge w_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      idx_q   <= '0;
      stall_q <= '0;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      fv_q    <= 1'b0;
      fsrc_q  <= 1'b0;
      abort_q <= 1'b0;
      asrc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      stall_q <= stall_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
      fv_q    <= fv_d;
      fsrc_q  <= fsrc_d;
      abort_q <= abort_d;
      asrc_q  <= asrc_d;
    end
  end

  byte_bank u_bank (
    .clk  (w_clk),
    .rst  (rst),
    .we   (bank_we_c),
    .addr (idx_q),
    .din  (gnt_data_c),
    .q    (frame_data)
  );

  assign req0_ready  = rdy0_q;
  assign req1_ready  = rdy1_q;
  assign frame_valid = fv_q;
  assign frame_src   = fsrc_q;
  assign abort       = abort_q;
  assign abort_src   = asrc_q;

endmodule

// File: tb/tb_frame_wr_arbiter.sv
// Randomized scoreboard bench for frame_wr_arbiter against a frame-level model.
module tb_frame_wr_arbiter;

  localparam int TIMEOUT = 15;

  logic        w_clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        frame_valid;
  logic [63:0] frame_data;
  logic        frame_src;
  logic        frame_ready;
  logic        abort;
  logic        abort_src;

  frame_wr_arbiter #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
    .w_clk       (w_clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_src   (frame_src),
    .frame_ready (frame_ready),
    .abort       (abort),
    .abort_src   (abort_src)
  );

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  // Source drivers
  bit          vld [2];
  bit [7:0]    dat [2];
  int          sent [2];
  int          limit [2];
  int unsigned gmin [2];
  int unsigned gmax [2];
  int unsigned gap [2];
  bit          seq [2];

  assign req0_valid = vld[0];
  assign req1_valid = vld[1];
  assign req0_data  = dat[0];
  assign req1_data  = dat[1];

  task automatic run_src(input int k);
    bit acc;
    forever begin
      @(negedge w_clk);
      acc = (k == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
      @(posedge w_clk);
      #1;
      if (acc) begin
        sent[k]++;
        vld[k] = 1'b0;
        gap[k] = $urandom_range(gmax[k], gmin[k]);
      end
      if (sent[k] >= limit[k]) begin
        vld[k] = 1'b0;
      end else if (!vld[k]) begin
        if (gap[k] > 0) gap[k]--;
        else begin
          vld[k] = 1'b1;
          dat[k] = seq[k] ? 8'(17 * ((sent[k] % 8) + 1)) : 8'($urandom);
        end
      end
    end
  endtask

  // Reference model: who owns the bank, bytes collected so far, stall run length
  int          cyc = 0;
  int          m_owner = -1;
  int          m_last = 1;
  int          m_stall = 0;
  bit          m_hold = 1'b0;
  bit [7:0]    m_bytes [$];
  bit          e_rdy0, e_rdy1, e_fv, e_abort;
  bit [63:0]   exp_data_q [$];
  bit          exp_src_q [$];
  bit          exp_abort_q [$];

  always @(posedge w_clk) begin
    bit [63:0] w;
    cyc++;
    e_abort = 1'b0;
    if (rst) begin
      m_owner = -1; m_last = 1; m_stall = 0; m_hold = 1'b0;
      m_bytes.delete(); exp_data_q.delete(); exp_src_q.delete(); exp_abort_q.delete();
    end else if (m_hold) begin
      if (frame_ready) m_hold = 1'b0;
    end else if (m_owner < 0) begin
      if (vld[0] && vld[1]) m_owner = 1 - m_last;
      else if (vld[0])      m_owner = 0;
      else if (vld[1])      m_owner = 1;
      if (m_owner >= 0) begin
        m_last = m_owner; m_stall = 0; m_bytes.delete();
      end
    end else if (vld[m_owner]) begin
      m_bytes.push_back(dat[m_owner]);
      m_stall = 0;
      if (m_bytes.size() == 8) begin
        for (int i = 0; i < 8; i++) w[8*i +: 8] = m_bytes[i];
        exp_data_q.push_back(w);
        exp_src_q.push_back(m_owner[0]);
        m_hold  = 1'b1;
        m_owner = -1;
      end
    end else begin
      m_stall++;
      if (m_stall == TIMEOUT) begin
        exp_abort_q.push_back(m_owner[0]);
        e_abort = 1'b1;
        m_owner = -1;
      end
    end
    e_rdy0 = (m_owner == 0);
    e_rdy1 = (m_owner == 1);
    e_fv   = m_hold;
  end

  // Scoreboard
  int        n_cmp = 0;
  int        n_err = 0;
  bit        mon_en = 1'b0;
  int        frames_seen = 0;
  int        aborts_seen = 0;
  bit [63:0] last_data;
  bit        last_src;
  bit        rec_en = 1'b0;
  int        hs_cyc [$];
  bit        hs_src [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge w_clk) begin
    if (mon_en) begin
      check("flags rdy0/rdy1/fvalid/abort", {req0_ready, req1_ready, frame_valid, abort},
            {e_rdy0, e_rdy1, e_fv, e_abort});
      if (abort) begin
        aborts_seen++;
        if (exp_abort_q.size() == 0) check("abort_unexpected", abort, 0);
        else check("abort_src", abort_src, exp_abort_q.pop_front());
      end
      if (frame_valid) begin
        if (exp_data_q.size() == 0) check("frame_unexpected", frame_valid, 0);
        else begin
          check("frame_data", frame_data, exp_data_q[0]);
          check("frame_src", frame_src, exp_src_q[0]);
          if (frame_ready) begin
            void'(exp_data_q.pop_front());
            void'(exp_src_q.pop_front());
            frames_seen++;
            last_data = frame_data;
            last_src  = frame_src;
            if (rec_en) begin
              hs_cyc.push_back(cyc);
              hs_src.push_back(frame_src);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge w_clk);
    #2;
  endtask

  task automatic cfg_src(input int k, input int lim, input int unsigned gl,
                         input int unsigned gh, input bit sq);
    sent[k] = 0; limit[k] = lim; gmin[k] = gl; gmax[k] = gh; seq[k] = sq; gap[k] = 0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int target = frames_seen + n;
    for (int i = 0; i < budget && frames_seen < target; i++) step();
    check("wait_frames", frames_seen >= target, 1);
  endtask

  task automatic wait_aborts(input int n, input int budget);
    int target = aborts_seen + n;
    for (int i = 0; i < budget && aborts_seen < target; i++) step();
    check("wait_aborts", aborts_seen >= target, 1);
  endtask

  task automatic drain();
    limit[0] = sent[0]; limit[1] = sent[1];
    frame_ready = 1'b1;
    repeat (40) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, a0, ok;
    rst = 1'b1;
    frame_ready = 1'b0;
    for (int k = 0; k < 2; k++) cfg_src(k, 0, 0, 0, 0);
    fork
      run_src(0);
      run_src(1);
    join_none
    repeat (3) step();
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge w_clk);
    check("reset frame_data", frame_data, 0);
    check("reset frame_src", frame_src, 0);
    check("reset abort_src", abort_src, 0);
    step();

    // Single frame 0x11..0x88 from requester 0
    frame_ready = 1'b1;
    cfg_src(0, 8, 0, 0, 1);
    wait_frames(1, 40);
    check("single data", last_data, 64'h8877665544332211);
    check("single src", last_src, 0);
    repeat (3) step();

    // Round-robin with both always valid
    cfg_src(0, 100000, 0, 0, 0);
    cfg_src(1, 100000, 0, 0, 0);
    rec_en = 1'b1;
    wait_frames(6, 100);
    rec_en = 1'b0;
    for (int i = 1; i < hs_cyc.size(); i++) begin
      check("rr period", hs_cyc[i] - hs_cyc[i-1], 10);
      check("rr alternate", hs_src[i] ^ hs_src[i-1], 1);
    end
    drain();

    // Back-pressure for 20 cycles
    frame_ready = 1'b0;
    cfg_src(1, 8, 0, 0, 0);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge w_clk);
      ok = frame_valid;
    end
    check("bp frame_valid wait", ok, 1);
    repeat (20) begin
      @(negedge w_clk);
      check("bp readies low", {req0_ready, req1_ready}, 0);
    end
    step();
    frame_ready = 1'b1;
    cfg_src(0, 8, 0, 0, 1);
    wait_frames(2, 40);
    check("bp next frame src", last_src, 0);
    repeat (3) step();

    // Timeout: requester 1 sends 3 bytes then stops
    f0 = frames_seen;
    cfg_src(1, 3, 0, 0, 0);
    wait_aborts(1, 60);
    check("timeout no frame", frames_seen, f0);
    cfg_src(0, 8, 0, 0, 1);
    wait_frames(1, 40);
    check("after abort data", last_data, 64'h8877665544332211);
    repeat (3) step();

    // Reset after 5 bytes
    cfg_src(0, 1000, 0, 0, 1);
    for (int i = 0; i < 40 && sent[0] < 5; i++) step();
    check("reset test bytes sent", sent[0] >= 5, 1);
    a0 = aborts_seen;
    rst = 1'b1;
    limit[0] = 0;
    vld[0] = 1'b0;
    step();
    rst = 1'b0;
    @(negedge w_clk);
    check("midreset frame_data", frame_data, 0);
    check("midreset frame_src", frame_src, 0);
    check("midreset abort_src", abort_src, 0);
    step();
    cfg_src(0, 8, 0, 0, 1);
    cfg_src(1, 8, 0, 0, 0);
    wait_frames(1, 40);
    check("post-reset src", last_src, 0);
    check("post-reset data", last_data, 64'h8877665544332211);
    wait_frames(1, 40);
    check("post-reset no abort", aborts_seen, a0);
    repeat (3) step();

    // Gaps of 1..14 cycles never time out
    a0 = aborts_seen;
    cfg_src(0, 8, 1, 14, 1);
    wait_frames(1, 200);
    check("gaps data", last_data, 64'h8877665544332211);
    check("gaps no abort", aborts_seen, a0);
    repeat (3) step();

    // Random traffic, random gaps (some long enough to abort), random frame_ready
    cfg_src(0, 100000, 0, 17, 0);
    cfg_src(1, 100000, 0, 17, 0);
    gmin[0] = 0; gmin[1] = 0;
    repeat (2500) begin
      step();
      frame_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) begin
        gmax[0] = $urandom_range(17, 0);
        gmax[1] = $urandom_range(17, 0);
      end
    end
    drain();
    check("frames left unconsumed", exp_data_q.size(), 0);
    check("aborts left unseen", exp_abort_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
